// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and helpers for the conv MAC accumulator
package conv_pkg;

  localparam int K_DEF    = 3;
  localparam int DW_DEF   = 8;
  localparam int ACCW_DEF = 32;
  localparam int OW_DEF   = 8;
  localparam int SHW_DEF  = 5;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Floor shift, then clamp into the signed ow-bit range; caller keeps the low ow bits.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] value,
                                                   input int shift, input int ow);
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v  = value >>> shift;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_mac_acc_if.sv
// rtl/conv_mac_acc_if.sv - beat input and result output streams of conv_mac_acc
interface conv_mac_acc_if #(
  parameter int K    = conv_pkg::K_DEF,
  parameter int DW   = conv_pkg::DW_DEF,
  parameter int ACCW = conv_pkg::ACCW_DEF,
  parameter int OW   = conv_pkg::OW_DEF,
  parameter int SHW  = conv_pkg::SHW_DEF
);
  localparam int N = K * K;

  logic            in_valid_i;
  logic            in_ready_o;
  logic            in_last_i;
  logic [N*DW-1:0] pix_i;
  logic [N*DW-1:0] wgt_i;
  logic [ACCW-1:0] bias_i;
  logic [SHW-1:0]  shift_i;
  logic            relu_en_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [OW-1:0]   out_data_o;
  logic [15:0]     ch_cnt_o;

  modport slave (
    input  in_valid_i, in_last_i, pix_i, wgt_i, bias_i, shift_i, relu_en_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, ch_cnt_o
  );

  modport master (
    output in_valid_i, in_last_i, pix_i, wgt_i, bias_i, shift_i, relu_en_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, ch_cnt_o
  );
endinterface

// File: rtl/mac_adder_tree.sv
// rtl/mac_adder_tree.sv - combinational balanced signed adder tree over N terms
module mac_adder_tree import conv_pkg::*; #(
  parameter  int N  = 9,
  parameter  int IW = 16,
  localparam int LV = clog2(N),
  localparam int SW = IW + LV
) (
  input  logic [N*IW-1:0]  terms,
  output logic signed [SW-1:0] sum
);
  localparam int P = 1 << LV;

  // Leaves padded to a power of two so every level pairs cleanly.
  logic signed [SW-1:0] node [LV+1][P];

  for (genvar j = 0; j < P; j++) begin : g_leaf
    if (j < N) begin : g_in
      assign node[0][j] = SW'($signed(terms[j*IW +: IW]));
    end else begin : g_pad
      assign node[0][j] = '0;
    end
  end

  for (genvar l = 0; l < LV; l++) begin : g_lvl
    for (genvar j = 0; j < P; j++) begin : g_node
      if (j < (P >> (l + 1))) begin : g_add
        assign node[l+1][j] = node[l][2*j] + node[l][2*j+1];
      end else begin : g_idle
        assign node[l+1][j] = '0;
      end
    end
  end

  assign sum = node[LV][0];
endmodule

// File: rtl/conv_mac_acc.sv
// rtl/conv_mac_acc.sv - pipelined KxK MAC accumulating channels into a saturated output pixel
module conv_mac_acc import conv_pkg::*; #(
  parameter int K    = K_DEF,
  parameter int DW   = DW_DEF,
  parameter int ACCW = ACCW_DEF,
  parameter int OW   = OW_DEF,
  parameter int SHW  = SHW_DEF
) (
  input logic           clk_i,
  input logic           rst_i,
  conv_mac_acc_if.slave bus
);
  localparam int N  = K * K;
  localparam int PW = 2 * DW;
  localparam int SW = PW + clog2(N);

  logic en;
  logic first_flag;

  logic                   s1_valid, s1_last, s1_first, s1_relu;
  logic [N*PW-1:0]        s1_prod;
  logic signed [ACCW-1:0] s1_bias;
  logic [SHW-1:0]         s1_shift;

  logic signed [SW-1:0]   tree_sum;

  logic                   s2_valid, s2_last, s2_first, s2_relu;
  logic signed [SW-1:0]   s2_sum;
  logic signed [ACCW-1:0] s2_bias;
  logic [SHW-1:0]         s2_shift;

  logic signed [ACCW-1:0] acc, acc_next, relu_v;
  logic                   out_valid;
  logic [OW-1:0]          out_data;
  logic [15:0]            ch_cnt;

  // A held result blocks the whole pipeline so nothing is overwritten.
  assign en              = !(out_valid && !bus.out_ready_i);
  assign bus.in_ready_o  = en;
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o  = out_data;
  assign bus.ch_cnt_o    = ch_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      first_flag <= 1'b1;
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s1_first   <= 1'b0;
      s1_relu    <= 1'b0;
      s1_prod    <= '0;
      s1_bias    <= '0;
      s1_shift   <= '0;
    end else if (en) begin
      s1_valid <= bus.in_valid_i;
      if (bus.in_valid_i) begin
        for (int j = 0; j < N; j++)
          s1_prod[j*PW +: PW] <= PW'($signed(bus.pix_i[j*DW +: DW])) *
                                 PW'($signed(bus.wgt_i[j*DW +: DW]));
        s1_last    <= bus.in_last_i;
        s1_first   <= first_flag;
        s1_relu    <= bus.relu_en_i;
        s1_bias    <= bus.bias_i;
        s1_shift   <= bus.shift_i;
        first_flag <= bus.in_last_i;
      end
    end
  end

  mac_adder_tree #(.N(N), .IW(PW)) u_tree (
    .terms (s1_prod),
    .sum   (tree_sum)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_first <= 1'b0;
      s2_relu  <= 1'b0;
      s2_sum   <= '0;
      s2_bias  <= '0;
      s2_shift <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_first <= s1_first;
      s2_relu  <= s1_relu;
      s2_sum   <= tree_sum;
      s2_bias  <= s1_bias;
      s2_shift <= s1_shift;
    end
  end

  always_comb begin
    acc_next = (s2_first ? s2_bias : acc) + ACCW'(s2_sum);
    relu_v   = (s2_relu && acc_next[ACCW-1]) ? '0 : acc_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc       <= '0;
      ch_cnt    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= s2_valid && s2_last;
      if (s2_valid) begin
        acc    <= acc_next;
        ch_cnt <= s2_first ? 16'd1 : ((ch_cnt == 16'hFFFF) ? ch_cnt : ch_cnt + 16'd1);
        if (s2_last)
          out_data <= OW'(sat_shift(64'(relu_v), int'(s2_shift), OW));
      end
    end
  end
endmodule

// File: tb/tb_conv_mac_acc.sv
// tb/tb_conv_mac_acc.sv - randomized self-checking bench for conv_mac_acc
module tb_conv_mac_acc;
  localparam int K = 3, DW = 8, ACCW = 32, OW = 8, SHW = 5, N = K * K;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_mac_acc_if #(.K(K), .DW(DW), .ACCW(ACCW), .OW(OW), .SHW(SHW)) bus();

  conv_mac_acc #(.K(K), .DW(DW), .ACCW(ACCW), .OW(OW), .SHW(SHW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int     n_vec = 0;
  int     n_bad = 0;
  int     cur_pix[N];
  int     cur_wgt[N];
  int     got[$];
  int     exp_q[$];
  longint m_acc;
  bit     m_new = 1'b1;

  always @(negedge clk)
    if (!rst && bus.out_valid_o && bus.out_ready_i)
      got.push_back(int'($signed(bus.out_data_o)));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  function automatic longint dot();
    longint s = 0;
    for (int j = 0; j < N; j++) s += longint'(cur_pix[j]) * longint'(cur_wgt[j]);
    return s;
  endfunction

  function automatic int model_out(input longint a, input int sh, input bit relu);
    longint v;
    longint d;
    v = a;
    if (relu && v < 0) v = 0;
    d = longint'(1) << sh;
    if (v >= 0) v = v / d;
    else v = -((-v + d - 1) / d);
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return int'(v);
  endfunction

  task automatic set_window(input int p, input int w);
    for (int j = 0; j < N; j++) begin
      cur_pix[j] = p;
      cur_wgt[j] = w;
    end
  endtask

  task automatic send_beat(input int bias, input int shift, input bit relu, input bit last);
    int waited;
    bit taken;
    for (int j = 0; j < N; j++) begin
      bus.pix_i[j*DW +: DW] = 8'(cur_pix[j]);
      bus.wgt_i[j*DW +: DW] = 8'(cur_wgt[j]);
    end
    bus.bias_i     = 32'(bias);
    bus.shift_i    = 5'(shift);
    bus.relu_en_i  = relu;
    bus.in_last_i  = last;
    bus.in_valid_i = 1'b1;
    waited = 0;
    taken  = 1'b0;
    while (!taken && waited < 200) begin
      @(negedge clk);
      taken = bus.in_ready_o;
      waited++;
    end
    n_vec++;
    if (!taken) begin
      n_bad++;
      $display("FAIL accept_timeout: in_ready_o=%0b required 1", bus.in_ready_o);
    end
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    if (taken) begin
      if (m_new) m_acc = longint'(bias);
      m_acc += dot();
      m_acc = longint'(int'(m_acc));
      if (last) exp_q.push_back(model_out(m_acc, shift, relu));
      m_new = last;
    end
  endtask

  task automatic wait_got(input int n, output bit ok);
    int c = 0;
    while (got.size() < n && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
    ok = (got.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid_i = 1'b0;
    bus.in_last_i = 1'b0;
    bus.pix_i = '0;
    bus.wgt_i = '0;
    bus.bias_i = '0;
    bus.shift_i = '0;
    bus.relu_en_i = 1'b0;
    bus.out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (bus.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid_o); end
    n_vec++;
    if (bus.out_data_o !== 8'd0) begin n_bad++; $display("FAIL reset_out_data: got %0d want 0", bus.out_data_o); end
    n_vec++;
    if (bus.ch_cnt_o !== 16'd0) begin n_bad++; $display("FAIL reset_ch_cnt: got %0d want 0", bus.ch_cnt_o); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (bus.in_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready_o); end
  endtask

  task automatic test_ones_latency();
    set_window(1, 1);
    send_beat(0, 0, 1'b0, 1'b1);
    for (int c = 1; c <= 2; c++) begin
      n_vec++;
      if (bus.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL latency_early t+%0d: out_valid_o=%0b want 0", c, bus.out_valid_o); end
      @(posedge clk); #1;
    end
    n_vec++;
    if (bus.out_valid_o !== 1'b1) begin n_bad++; $display("FAIL latency_t3_valid: got %0b want 1", bus.out_valid_o); end
    n_vec++;
    if ($signed(bus.out_data_o) !== 8'sd9) begin n_bad++; $display("FAIL ones_data: got %0d want 9", $signed(bus.out_data_o)); end
    n_vec++;
    if (bus.ch_cnt_o !== 16'd1) begin n_bad++; $display("FAIL ones_ch_cnt: got %0d want 1", bus.ch_cnt_o); end
    @(posedge clk); #1;
    got.delete();
    exp_q.delete();
  endtask

  task automatic test_saturate_big();
    bit ok;
    int v;
    set_window(-128, -128);
    send_beat(0, 0, 1'b0, 1'b1);
    send_beat(0, 14, 1'b0, 1'b1);
    wait_got(2, ok);
    n_vec++;
    if (!ok) begin n_bad++; $display("FAIL big_timeout: results %0d want 2", got.size()); end
    v = (got.size() > 0) ? got.pop_front() : -999;
    n_vec++;
    if (v !== 127) begin n_bad++; $display("FAIL big_shift0: got %0d want 127", v); end
    v = (got.size() > 0) ? got.pop_front() : -999;
    n_vec++;
    if (v !== 9) begin n_bad++; $display("FAIL big_shift14: got %0d want 9", v); end
    exp_q.delete();
  endtask

  task automatic test_multi_channel();
    bit ok;
    int v;
    set_window(2, 3);
    for (int b = 0; b < 3; b++) send_beat(10, 0, 1'b0, b == 2);
    wait_got(1, ok);
    v = (got.size() > 0) ? got.pop_front() : -999;
    n_vec++;
    if (v !== 127) begin n_bad++; $display("FAIL multi_shift0: got %0d want 127", v); end
    n_vec++;
    if (bus.ch_cnt_o !== 16'd3) begin n_bad++; $display("FAIL multi_ch_cnt: got %0d want 3", bus.ch_cnt_o); end
    for (int b = 0; b < 3; b++) send_beat(10, 2, 1'b0, b == 2);
    wait_got(1, ok);
    v = (got.size() > 0) ? got.pop_front() : -999;
    n_vec++;
    if (v !== 43) begin n_bad++; $display("FAIL multi_shift2: got %0d want 43", v); end
    exp_q.delete();
  endtask

  task automatic test_relu();
    bit ok;
    int v;
    int want[3] = '{-9, 0, -128};
    set_window(1, -1);
    send_beat(0, 0, 1'b0, 1'b1);
    send_beat(0, 0, 1'b1, 1'b1);
    send_beat(-500, 0, 1'b0, 1'b1);
    wait_got(3, ok);
    for (int i = 0; i < 3; i++) begin
      v = (got.size() > 0) ? got.pop_front() : -999;
      n_vec++;
      if (v !== want[i]) begin n_bad++; $display("FAIL relu_case%0d: got %0d want %0d", i, v, want[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit seen;
    int v;
    logic [OW-1:0] d0;
    bus.out_ready_i = 1'b0;
    fork
      begin
        for (int k = 1; k <= 4; k++) begin
          set_window(1, k);
          send_beat(0, 0, 1'b0, 1'b1);
        end
      end
      begin
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
          @(posedge clk); #1;
          seen = bus.out_valid_o;
        end
        n_vec++;
        if (!seen) begin n_bad++; $display("FAIL stall_valid_timeout: out_valid_o=%0b want 1", bus.out_valid_o); end
        d0 = bus.out_data_o;
        repeat (5) begin
          @(posedge clk); #1;
          n_vec++;
          if (bus.in_ready_o !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready: got %0b want 0", bus.in_ready_o); end
          n_vec++;
          if (bus.out_data_o !== d0) begin n_bad++; $display("FAIL stall_data_stable: got %0d want %0d", bus.out_data_o, d0); end
        end
        bus.out_ready_i = 1'b1;
      end
    join
    wait_got(4, ok);
    repeat (6) @(posedge clk);
    #1;
    n_vec++;
    if (got.size() != 4) begin n_bad++; $display("FAIL b2b_count: got %0d results want 4", got.size()); end
    for (int k = 1; k <= 4; k++) begin
      v = (got.size() > 0) ? got.pop_front() : -999;
      n_vec++;
      if (v !== 9 * k) begin n_bad++; $display("FAIL b2b_order%0d: got %0d want %0d", k, v, 9 * k); end
    end
    got.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int v;
    set_window(5, 5);
    send_beat(0, 0, 1'b0, 1'b0);
    send_beat(0, 0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (bus.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL midrst_valid_during: got %0b want 0", bus.out_valid_o); end
    rst = 1'b0;
    n_vec++;
    if (bus.ch_cnt_o !== 16'd0) begin n_bad++; $display("FAIL midrst_ch_cnt: got %0d want 0", bus.ch_cnt_o); end
    @(posedge clk); #1;
    n_vec++;
    if (bus.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL midrst_valid_after: got %0b want 0", bus.out_valid_o); end
    m_new = 1'b1;
    got.delete();
    exp_q.delete();
    set_window(1, 1);
    send_beat(0, 0, 1'b0, 1'b1);
    wait_got(1, ok);
    v = (got.size() > 0) ? got.pop_front() : -999;
    n_vec++;
    if (v !== 9) begin n_bad++; $display("FAIL midrst_result: got %0d want 9", v); end
    n_vec++;
    if (bus.ch_cnt_o !== 16'd1) begin n_bad++; $display("FAIL midrst_result_ch_cnt: got %0d want 1", bus.ch_cnt_o); end
    exp_q.delete();
  endtask

  task automatic test_random();
    bit ok;
    bit done;
    int n_exp;
    int v;
    int w;
    done = 1'b0;
    fork
      begin
        for (int p = 0; p < 25; p++) begin
          int nb;
          int bias;
          int sh;
          bit relu;
          nb   = int'($urandom_range(1, 4));
          bias = int'($urandom_range(0, 2000000)) - 1000000;
          sh   = int'($urandom_range(0, 20));
          relu = 1'($urandom_range(0, 1));
          for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < N; j++) begin
              cur_pix[j] = int'($urandom_range(0, 255)) - 128;
              cur_wgt[j] = int'($urandom_range(0, 255)) - 128;
            end
            send_beat(bias, sh, relu, b == nb - 1);
            if ($urandom_range(0, 4) == 0) begin
              @(posedge clk); #1;
            end
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.out_ready_i = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready_i = 1'b1;
      end
    join
    n_exp = exp_q.size();
    wait_got(n_exp, ok);
    n_vec++;
    if (!ok) begin n_bad++; $display("FAIL rand_count: got %0d results want %0d", got.size(), n_exp); end
    for (int i = 0; i < n_exp; i++) begin
      w = exp_q.pop_front();
      v = (got.size() > 0) ? got.pop_front() : -999;
      n_vec++;
      if (v !== w) begin n_bad++; $display("FAIL rand_pixel%0d: got %0d want %0d", i, v, w); end
    end
  endtask

  initial begin
    test_reset();
    test_ones_latency();
    test_saturate_big();
    test_multi_channel();
    test_relu();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/conv_mac_acc.md
Name: conv_mac_acc

Overview:
- Parametrised, pipelined successor to the fixed 3x3 int8 multiply-accumulate conv tap block.
- Computes a KxK dot product (pixel window × weights) each accepted beat.
- Accumulates dot products across input channels into one output pixel, starting from a per-output bias.
- On the last channel beat, applies optional ReLU, an arithmetic right shift and saturation, then emits the result on a valid/ready stream. Sits between the line-buffer/window generator and the output feature-map writer.

Parameters:
- K, 3, kernel side; taps N = K*K.
- DW, 8, signed pixel and weight width.
- ACCW, 32, signed accumulator and bias width; must be ≥ 2*DW + clog2(N) + 8.
- OW, 8, signed output width.
- SHW, 5, width of the shift-amount input.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  beat valid.
- in_ready_o  out  1  beat accepted when in_valid_i && in_ready_o.
- in_last_i  in  1  beat is the last input channel of this output pixel.
- pix_i  in  N*DW  flattened signed pixels; tap j at [j*DW +: DW].
- wgt_i  in  N*DW  flattened signed weights, same layout.
- bias_i  in  ACCW  signed bias; sampled on the first beat of a pixel.
- shift_i  in  SHW  right-shift amount; sampled on the last beat.
- relu_en_i  in  1  ReLU enable; sampled on the last beat.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream ready.
- out_data_o  out  OW  signed saturated result.
- ch_cnt_o  out  16  number of beats accumulated into the current pixel so far.

Behaviour:
- Reset values: out_valid_o = 0, out_data_o = 0, ch_cnt_o = 0; all pipeline valids and the accumulator cleared; first-beat flag set to 1.
- Stall: en = !(out_valid_o && !out_ready_i). in_ready_o = en. When en = 0, every pipeline register holds its value.
- Stage S1 (on accept): register N products pix[j]*wgt[j], each 2*DW signed full precision. Also register last, first, bias, shift and relu_en.
- Stage S2: register the signed sum of the N products, width 2*DW + clog2(N), built as a balanced adder tree. Valid and sideband move along with the data.
- Stage S3, when S2 valid and en:
  - acc_next = (first ? bias : acc) + sign_extend(sum) at ACCW width; acc <= acc_next.
  - ch_cnt_o <= first ? 1 : ch_cnt_o + 1, saturating at 0xFFFF.
- Output on a last beat:
  - v = relu_en ? max(acc_next, 0) : acc_next.
  - v = v >>> shift (arithmetic, truncating toward -inf).
  - out_data_o <= clamp(v, -2^(OW-1), 2^(OW-1)-1).
  - out_valid_o <= 1; the first-beat flag is set for the next beat.
- Non-last beats clear the first-beat flag and do not touch the output.
- Output handshake: out_valid_o drops after the transfer (out_valid_o && out_ready_i) unless a new result loads in the same cycle. A simultaneous transfer and new result is allowed; the new data replaces the old with no bubble.
- Latency: a last beat accepted in cycle t gives out_valid_o = 1 in cycle t+3 when there is no stall. Throughput is one beat per cycle.
- The first beat after reset is always treated as first.
- A single-beat pixel has first = last = 1, so the result is bias + sum.
- Reset mid-accumulation discards the partial sum and any in-flight beats.
- Accumulator overflow wraps modulo 2^ACCW. This is the user's responsibility, covered by the ACCW sizing rule.

Decomposition:
- Package conv_pkg holds:
  - clog2 helper function;
  - default constants K, DW, ACCW, OW;
  - function sat_shift(value, shift, OW) used by the output stage.
- One sub-module, mac_adder_tree: combinational N-input signed tree, parametrised by N and input width, instantiated between S1 and S2.

Test Plan (K=3, DW=8, ACCW=32, OW=8):
- All pix = 1, wgt = 1, bias = 0, last = 1, shift = 0, relu off → out_data_o = 9 in cycle t+3, ch_cnt_o = 1.
- All pix = -128, wgt = -128, single beat, bias = 0:
  - shift = 0 → 147456 saturates to 127;
  - shift = 14 → 9.
- Three beats with pix = 2, wgt = 3 (sum 54 each), bias = 10, last on beat 3:
  - shift = 0 → 172 saturates to 127;
  - shift = 2 → 43;
  - ch_cnt_o = 3.
- pix = 1, wgt = -1, bias = 0, single beat:
  - relu off → -9;
  - relu on → 0;
  - with bias = -500, relu off → -128 (saturated).
- Back-to-back single-beat pixels with out_ready_i held low for 5 cycles → in_ready_o low and out_data_o stable while stalled; after release, all results arrive in order with none lost or duplicated.
- Assert rst_i after 2 of 3 beats, then send one last beat with sum 9 and bias 0 → output is 9, not the stale partial; out_valid_o = 0 during and right after reset.
